// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: memory read port plus the decode valid/ready handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle memory reads, captures
// the returned byte into the instruction register and offers it to decode.
// Optional feature macro: FETCH_HALT_EN -- an all-ones instruction parks the
// unit in HALT after decode accepts it; only reset or jump leaves HALT.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              halted,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              capture_s;
    logic              halt_hit_s;
    logic              mem_read_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] instr_pc_r;
    logic              instr_valid_r;

    // PC wraps naturally at 2^ADDR_W; no carry is kept.
    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FETCH_HALT_EN
    logic halted_r;
    // The halt opcode is recognised from the instruction register while it is presented.
    assign halt_hit_s = (instr_r == {DATA_W{1'b1}});
    assign halted     = halted_r;
`else
    assign halt_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

    assign bus.mem_address = pc_r;
    assign bus.mem_read    = mem_read_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.instr_valid = instr_valid_r;

    // Next-state, next-PC and capture decision for the fetch sequence.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // A jump here only retargets the PC; starting is governed by run.
                if (jump) begin
                    pc_nxt_s = jump_target;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (run) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (jump) begin
                    pc_nxt_s    = jump_target;
                    state_nxt_s = run ? ISSUE : IDLE;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            CAPTURE: begin
                // A jump discards the byte arriving from memory.
                if (jump) begin
                    pc_nxt_s    = jump_target;
                    state_nxt_s = run ? ISSUE : IDLE;
                end else begin
                    capture_s   = 1'b1;
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = PRESENT;
                end
            end
            PRESENT: begin
                // Jump wins over the halt opcode; a coincident handshake still
                // delivers the presented instruction to decode.
                if (jump) begin
                    pc_nxt_s    = jump_target;
                    state_nxt_s = run ? ISSUE : IDLE;
                end else if (bus.instr_ready) begin
                    if (halt_hit_s) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = run ? ISSUE : IDLE;
                    end
                end else begin
                    state_nxt_s = PRESENT;
                end
            end
            HALT: begin
                if (jump) begin
                    pc_nxt_s    = jump_target;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    // State, PC, instruction register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            mem_read_r    <= 1'b0;
            instr_r       <= {DATA_W{1'b0}};
            instr_pc_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_r      <= 1'b0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            mem_read_r    <= (state_nxt_s == ISSUE);
            instr_valid_r <= (state_nxt_s == PRESENT);
`ifdef FETCH_HALT_EN
            halted_r      <= (state_nxt_s == HALT);
`endif
            if (capture_s) begin
                instr_r    <= bus.mem_data;
                instr_pc_r <= pc_r;
            end else begin
                instr_r    <= instr_r;
                instr_pc_r <= instr_pc_r;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 16x8 registered-read memory model
// and a scoreboard of expected {instr, instr_pc} pairs.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halted;
    logic [DATA_W-1:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W+ADDR_W-1:0] sb_q[$];

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(4'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .jump        (jump),
        .jump_target (jump_target),
        .halted      (halted),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Memory registers data_out on the edge where read is high.
    always @(posedge clk) begin
        if (bus.mem_read) bus.mem_data <= mem[bus.mem_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] i, input logic [ADDR_W-1:0] a);
        sb_q.push_back({i, a});
    endtask

    // Advance until instr_valid (bounded), then compare against the scoreboard head.
    task automatic wait_instr(input string tag, output int n);
        logic [DATA_W+ADDR_W-1:0] e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.instr_valid && n < 12);
        check({tag, "_valid"}, bus.instr_valid, 1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : {(DATA_W+ADDR_W){1'bx}};
        check({tag, "_instr"}, bus.instr, e[DATA_W+ADDR_W-1:ADDR_W]);
        check({tag, "_pc"}, bus.instr_pc, e[ADDR_W-1:0]);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = {i[3:0], 4'h5};
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF; mem[4] = 8'h44;
        bus.mem_data    = 8'h00;
        bus.instr_ready = 1'b1;
        reset = 1'b1; run = 1'b0; jump = 1'b0; jump_target = 4'h0;

        // Reset state.
        repeat (3) tick();
        check("rst_valid", bus.instr_valid, 0);
        check("rst_read", bus.mem_read, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_ipc", bus.instr_pc, 0);
        check("rst_halted", halted, 0);

        // Basic fetch stream: run sampled at edge N, mem_read in N+1, valid in N+3.
        reset = 1'b0; run = 1'b1;
        tick();
        check("f0_read", bus.mem_read, 1);
        check("f0_addr", bus.mem_address, 0);
        push(8'h11, 4'h0);
        wait_instr("f0", n);
        check("f0_latency", n, 2);
        tick();
        check("f1_read", bus.mem_read, 1);
        check("f1_addr", bus.mem_address, 1);
        push(8'h22, 4'h1);
        wait_instr("f1", n);
        check("f1_period", n, 2);

        // Backpressure on 8'h22.
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_instr", bus.instr, 8'h22);
            check("bp_ipc", bus.instr_pc, 1);
            check("bp_valid", bus.instr_valid, 1);
            check("bp_noread", bus.mem_read, 0);
        end
        bus.instr_ready = 1'b1;
        tick();
        check("bp_next_read", bus.mem_read, 1);
        check("bp_next_addr", bus.mem_address, 2);
        push(8'h33, 4'h2);
        wait_instr("f2", n);

        // Address 3 holds 8'hFF.
        tick();
        check("f3_addr", bus.mem_address, 3);
        push(8'hFF, 4'h3);
        wait_instr("f3", n);
        tick();
`ifdef FETCH_HALT_EN
        check("halt_flag", halted, 1);
        check("halt_noread", bus.mem_read, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("halt_hold_read", bus.mem_read, 0);
            check("halt_hold_flag", halted, 1);
        end
        jump = 1'b1; jump_target = 4'h0;
        tick();
        jump = 1'b0;
        check("halt_clear", halted, 0);
        push(8'h11, 4'h0);
        wait_instr("after_halt", n);
`else
        check("nohalt_flag", halted, 0);
        check("nohalt_read", bus.mem_read, 1);
        check("nohalt_addr", bus.mem_address, 4);
        push(8'h44, 4'h4);
        wait_instr("f4", n);
`endif

        // Jump coincident with handshake in PRESENT, then wrap E, F, 0.
        jump = 1'b1; jump_target = 4'hE;
        tick();
        jump = 1'b0;
        check("jmp_read", bus.mem_read, 1);
        check("jmp_addr", bus.mem_address, 4'hE);
        check("jmp_valid", bus.instr_valid, 0);
        push(8'hE5, 4'hE);
        push(8'hF5, 4'hF);
        push(8'h11, 4'h0);
        wait_instr("wrapE", n);
        wait_instr("wrapF", n);
        wait_instr("wrap0", n);

        // Jump during CAPTURE: the byte from address 1 is never presented.
        tick();
        check("cap_issue_addr", bus.mem_address, 1);
        tick();
        check("cap_noread", bus.mem_read, 0);
        jump = 1'b1; jump_target = 4'h8;
        tick();
        jump = 1'b0;
        check("cap_jmp_read", bus.mem_read, 1);
        check("cap_jmp_addr", bus.mem_address, 8);
        check("cap_jmp_valid", bus.instr_valid, 0);
        push(8'h85, 4'h8);
        wait_instr("cap8", n);

        // Reset while presenting.
        reset = 1'b1; bus.instr_ready = 1'b0;
        tick();
        check("rp_valid", bus.instr_valid, 0);
        check("rp_read", bus.mem_read, 0);
        check("rp_pc", bus.mem_address, 0);
        check("rp_instr", bus.instr, 0);
        reset = 1'b0; bus.instr_ready = 1'b1;
        push(8'h11, 4'h0);
        wait_instr("rp_first", n);

        // run dropped mid-fetch: the sequence completes, then IDLE.
        tick();
        check("drain_read", bus.mem_read, 1);
        run = 1'b0;
        push(8'h22, 4'h1);
        wait_instr("drain", n);
        tick();
        check("idle_valid", bus.instr_valid, 0);
        check("idle_read", bus.mem_read, 0);
        tick();
        check("idle_read2", bus.mem_read, 0);
        check("idle_pc", bus.mem_address, 2);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
